// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : RV32I-subset multicycle control FSM with a ready-based memory
//            handshake, a wait timeout and an illegal-instruction trap.
//            Define MC_BRANCH_EN to include the BRANCH and JAL paths.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control #(
   parameter int MEM_TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] inst,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_w,
   output logic [1:0]  mem_size,
   output logic        mem_unsigned,
   output logic        pc_w,
   output logic        inst_w,
   output logic        reg_w,
   output logic [1:0]  alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  result_src,
   output logic [3:0]  alu_op,
   output logic [2:0]  imm_type,
   output logic        fault,
   output logic [1:0]  fault_cause,
   output logic [3:0]  state
);

   localparam int CNT_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);
   localparam logic TIMEOUT_EN = (MEM_TIMEOUT != 0);

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SLL  = 4'd5;
   localparam logic [3:0] ALU_SRL  = 4'd6;
   localparam logic [3:0] ALU_SRA  = 4'd7;
   localparam logic [3:0] ALU_SLT  = 4'd8;
   localparam logic [3:0] ALU_SLTU = 4'd9;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_I   = 4'd2,
      S_UTYPE    = 4'd3,
      S_STORE    = 4'd4,
      S_LOAD     = 4'd5,
      S_ALU_WB   = 4'd6,
      S_MEM_ADDR = 4'd7,
      S_MEM_WB   = 4'd8,
      S_EXEC_R   = 4'd9,
      S_BRANCH   = 4'd10,
      S_JAL      = 4'd11,
      S_FAULT    = 4'd15
   } state_t;

   state_t           state_q, state_d, dec_next;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fault_q, fault_d;
   logic [1:0]       cause_q, cause_d;
   logic             timeout_hit;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       unused_bits;

   assign opcode      = inst[6:0];
   assign funct3      = inst[14:12];
   assign funct7      = inst[31:25];
   assign unused_bits = ^{inst[24:15], inst[11:7], zero};

   // alt selects sub/sra; callers decide when funct7[5] is meaningful
   function automatic logic [3:0] alu_dec(input logic [2:0] f3, input logic alt);
      logic [3:0] op;
      case (f3)
         3'd0:    op = alt ? ALU_SUB : ALU_ADD;
         3'd1:    op = ALU_SLL;
         3'd2:    op = ALU_SLT;
         3'd3:    op = ALU_SLTU;
         3'd4:    op = ALU_XOR;
         3'd5:    op = alt ? ALU_SRA : ALU_SRL;
         3'd6:    op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   always_comb begin
      imm_type = 3'd0;
      case (opcode)
         OP_STORE:  imm_type = 3'd1;
         OP_LUI:    imm_type = 3'd3;
`ifdef MC_BRANCH_EN
         OP_BRANCH: imm_type = 3'd2;
         OP_JAL:    imm_type = 3'd4;
`endif
         default:   imm_type = 3'd0;
      endcase
   end

   always_comb begin
      dec_next = S_FAULT;
      case (opcode)
         OP_IMM: dec_next = S_EXEC_I;
         OP_REG: begin
            if (funct7 == 7'b0000000)
               dec_next = S_EXEC_R;
            else if (funct7 == 7'b0100000 && (funct3 == 3'd0 || funct3 == 3'd5))
               dec_next = S_EXEC_R;
         end
         OP_LUI:   dec_next = S_UTYPE;
         OP_LOAD:  if (funct3 != 3'd3 && funct3 != 3'd6 && funct3 != 3'd7) dec_next = S_MEM_ADDR;
         OP_STORE: if (funct3[2] == 1'b0 && funct3[1:0] != 2'd3) dec_next = S_MEM_ADDR;
`ifdef MC_BRANCH_EN
         OP_BRANCH: if (funct3[2:1] == 2'b00) dec_next = S_BRANCH;
         OP_JAL:    dec_next = S_JAL;
`endif
         default: dec_next = S_FAULT;
      endcase
   end

   always_comb begin
      mem_req      = 1'b0;
      mem_w        = 1'b0;
      mem_size     = 2'd0;
      mem_unsigned = 1'b0;
      pc_w         = 1'b0;
      inst_w       = 1'b0;
      reg_w        = 1'b0;
      alu_src_a    = 2'd0;
      alu_src_b    = 2'd0;
      result_src   = 2'd0;
      alu_op       = ALU_ADD;
      case (state_q)
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_b  = 2'd2;
            result_src = 2'd2;
            pc_w       = mem_ready;
            inst_w     = mem_ready;
         end
         S_DECODE: begin
            alu_src_a = 2'd1;
            alu_src_b = 2'd1;
         end
         S_EXEC_R: begin
            alu_src_a = 2'd2;
            alu_op    = alu_dec(funct3, funct7[5]);
         end
         S_EXEC_I: begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd1;
            alu_op    = alu_dec(funct3, funct7[5] & (funct3 == 3'd5));
         end
         S_UTYPE: begin
            alu_src_a = 2'd3;
            alu_src_b = 2'd1;
         end
         S_MEM_ADDR: begin
            alu_src_a = 2'd2;
            alu_src_b = 2'd1;
         end
         S_LOAD: begin
            mem_req      = 1'b1;
            mem_size     = funct3[1:0];
            mem_unsigned = funct3[2];
         end
         S_STORE: begin
            mem_req  = 1'b1;
            mem_w    = 1'b1;
            mem_size = funct3[1:0];
         end
         S_MEM_WB: begin
            reg_w        = 1'b1;
            result_src   = 2'd1;
            mem_size     = funct3[1:0];
            mem_unsigned = funct3[2];
         end
         S_ALU_WB: reg_w = 1'b1;
`ifdef MC_BRANCH_EN
         S_BRANCH: begin
            alu_src_a = 2'd2;
            alu_op    = ALU_SUB;
            pc_w      = zero ^ funct3[0];
         end
         S_JAL: begin
            pc_w      = 1'b1;
            alu_src_a = 2'd1;
            alu_src_b = 2'd2;
         end
`endif
         default: ;
      endcase
      // No architectural write may slip out while reset is held
      if (rst) begin
         pc_w   = 1'b0;
         inst_w = 1'b0;
         reg_w  = 1'b0;
         mem_w  = 1'b0;
      end
   end

   assign timeout_hit = TIMEOUT_EN && mem_req && !mem_ready && (cnt_q == TIMEOUT_CNT);

   always_comb begin
      state_d = state_q;
      fault_d = fault_q;
      cause_d = cause_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready)        state_d = S_DECODE;
            else if (timeout_hit) state_d = S_FAULT;
         end
         S_DECODE:                     state_d = dec_next;
         S_EXEC_R, S_EXEC_I, S_UTYPE:  state_d = S_ALU_WB;
         S_MEM_ADDR:                   state_d = opcode[5] ? S_STORE : S_LOAD;
         S_LOAD: begin
            if (mem_ready)        state_d = S_MEM_WB;
            else if (timeout_hit) state_d = S_FAULT;
         end
         S_STORE: begin
            if (mem_ready)        state_d = S_FETCH;
            else if (timeout_hit) state_d = S_FAULT;
         end
         S_MEM_WB, S_ALU_WB:           state_d = S_FETCH;
`ifdef MC_BRANCH_EN
         S_BRANCH:                     state_d = S_FETCH;
         S_JAL:                        state_d = S_ALU_WB;
`endif
         S_FAULT:                      state_d = S_FAULT;
         default:                      state_d = S_FETCH;
      endcase
      if (state_q != S_FAULT && state_d == S_FAULT) begin
         fault_d = 1'b1;
         cause_d = timeout_hit ? 2'b10 : 2'b01;
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (mem_ready || state_d != state_q)
         cnt_d = '0;
      else if (mem_req)
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
         fault_q <= 1'b0;
         cause_q <= 2'b00;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
         cause_q <= cause_d;
      end
   end

   assign fault       = fault_q;
   assign fault_cause = cause_q;
   assign state       = state_q;

endmodule
`default_nettype wire
